spatz_vrf_sequencer: RTL and testbench

// - Element-walk stage directly downstream of the Spatz decoder/CSR controller.
// - Accepts one decoded vector op (vd, vstart, vl, vsew) and turns it into a stream of

---
 rtl/spatz_vrf_sequencer_pkg.sv | 54 +++++
 rtl/spatz_vrf_sequencer_if.sv | 21 ++
 rtl/spatz_vrf_sequencer_be_gen.sv | 22 ++
 rtl/spatz_vrf_sequencer.sv | 146 ++++++++++++++
 tb/tb_spatz_vrf_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spatz_vrf_sequencer_pkg.sv
// Shared types and sizing for the Spatz VRF element-walk sequencer.
// Beats are DP_BYTES wide; byte pointers cover a full LMUL=8 register group.
package spatz_vrf_sequencer_pkg;

  localparam int unsigned VLEN        = 256;
  localparam int unsigned DP_BYTES    = 8;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned VLENB       = VLEN / 8;
  localparam int unsigned MAXVL       = 8 * VLENB;
  localparam int unsigned VL_W        = $clog2(MAXVL + 1);
  localparam int unsigned WORD_W      = $clog2(VLENB / DP_BYTES);
  localparam int unsigned BPTR_W      = $clog2(8 * VLENB + 1);
  localparam int unsigned BOFF_W      = VL_W + 2;
  localparam int unsigned DP_SHIFT    = $clog2(DP_BYTES);
  localparam int unsigned VLENB_SHIFT = $clog2(VLENB);

  typedef enum logic [1:0] {
    EW_8  = 2'd0,
    EW_16 = 2'd1,
    EW_32 = 2'd2
  } vew_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [VL_W-1:0]   vlen_t;
  typedef logic [BPTR_W-1:0] bptr_t;
  typedef logic [BPTR_W:0]   bpos_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [4:0]      vd;
    vlen_t           vstart;
    vlen_t           vl;
    logic [1:0]      vsew;
  } seq_req_t;

  typedef struct packed {
    logic [4:0]          vreg;
    logic [WORD_W-1:0]   word;
    logic [DP_BYTES-1:0] be;
    logic                first;
    logic                last;
    logic [ID_W-1:0]     id;
  } seq_beat_t;

  // Element count scaled to a byte offset; wide enough for vl<<2 without clamping.
  function automatic logic [BOFF_W-1:0] byte_off(vlen_t n, logic [1:0] sew);
    return BOFF_W'(n) << sew;
  endfunction

endpackage

// File: rtl/spatz_vrf_sequencer_if.sv
// Request and beat channels of the sequencer; master is the sequencer side.
interface spatz_vrf_sequencer_if;
  import spatz_vrf_sequencer_pkg::*;

  logic      req_valid;
  logic      req_ready;
  seq_req_t  req;
  logic      beat_valid;
  logic      beat_ready;
  seq_beat_t beat;

  modport master (
    input  req_valid, req, beat_ready,
    output req_ready, beat_valid, beat
  );

  modport slave (
    output req_valid, req, beat_ready,
    input  req_ready, beat_valid, beat
  );
endinterface

// File: rtl/spatz_vrf_sequencer_be_gen.sv
// Byte enables and last-beat flag for the beat starting at byte pointer ptr_i,
// restricted to the body byte window [sb_i, eb_i).
module spatz_vrf_sequencer_be_gen
  import spatz_vrf_sequencer_pkg::*;
(
  input  bptr_t               ptr_i,
  input  bptr_t               sb_i,
  input  bptr_t               eb_i,
  output logic [DP_BYTES-1:0] be_o,
  output logic                last_o
);

  always_comb begin
    be_o = '0;
    for (int unsigned i = 0; i < DP_BYTES; i++) begin
      be_o[i] = ((bpos_t'(ptr_i) + bpos_t'(i)) >= bpos_t'(sb_i)) &&
                ((bpos_t'(ptr_i) + bpos_t'(i)) <  bpos_t'(eb_i));
    end
    last_o = (bpos_t'(ptr_i) + bpos_t'(DP_BYTES)) >= bpos_t'(eb_i);
  end

endmodule

// File: rtl/spatz_vrf_sequencer.sv
// Walks one decoded vector op across its VRF register group, emitting one
// DP_BYTES beat per handshake, then pulses done with the op id.
module spatz_vrf_sequencer
  import spatz_vrf_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  spatz_vrf_sequencer_if.master bus,
  output logic                  done_o,
  output logic [ID_W-1:0]       done_id_o,
  output logic                  done_err_o,
  output logic                  busy_o
);

  state_e          state_q, state_d;
  bptr_t           ptr_q, ptr_d;
  bptr_t           sb_q, sb_d;
  bptr_t           eb_q, eb_d;
  logic [4:0]      vd_q, vd_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            first_q, first_d;
  logic            done_q, done_d;
  logic [ID_W-1:0] done_id_q, done_id_d;
  logic            done_err_q, done_err_d;
  seq_beat_t       beat_q, beat_d;

  logic [BOFF_W-1:0]   sb_w, eb_full_w, eb_w;
  logic [DP_BYTES-1:0] be_w;
  logic                last_w;
  logic                illegal_sew;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sb_q       <= '0;
      eb_q       <= '0;
      vd_q       <= '0;
      id_q       <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      done_err_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sb_q       <= sb_d;
      eb_q       <= eb_d;
      vd_q       <= vd_d;
      id_q       <= id_d;
      first_q    <= first_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      done_err_q <= done_err_d;
      beat_q     <= beat_d;
    end
  end

  // Next-state: accept, walk, finish; flush overrides everything including accept.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sb_d       = sb_q;
    eb_d       = eb_q;
    vd_d       = vd_q;
    id_d       = id_q;
    first_d    = first_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    done_err_d = 1'b0;

    sb_w        = byte_off(bus.req.vstart, bus.req.vsew);
    eb_full_w   = byte_off(bus.req.vl, bus.req.vsew);
    eb_w        = (eb_full_w > BOFF_W'(8 * VLENB)) ? BOFF_W'(8 * VLENB) : eb_full_w;
    illegal_sew = bus.req.vsew > 2'(EW_32);

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (illegal_sew || (sb_w >= eb_w)) begin
              done_d     = 1'b1;
              done_id_d  = bus.req.id;
              done_err_d = illegal_sew;
            end else begin
              sb_d    = bptr_t'(sb_w);
              eb_d    = bptr_t'(eb_w);
              ptr_d   = bptr_t'(sb_w) & ~bptr_t'(DP_BYTES - 1);
              vd_d    = bus.req.vd;
              id_d    = bus.req.id;
              first_d = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.beat_ready) begin
            if (beat_q.last) begin
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              done_id_d = id_q;
            end else begin
              ptr_d   = ptr_q + bptr_t'(DP_BYTES);
              first_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  spatz_vrf_sequencer_be_gen i_be_gen (
    .ptr_i  (ptr_d),
    .sb_i   (sb_d),
    .eb_i   (eb_d),
    .be_o   (be_w),
    .last_o (last_w)
  );

  // Beat payload is built from next-state so it is registered alongside valid.
  always_comb begin
    beat_d = '0;
    if (state_d == ST_RUN) begin
      beat_d.vreg  = vd_d + 5'(ptr_d >> VLENB_SHIFT);
      beat_d.word  = WORD_W'(ptr_d >> DP_SHIFT);
      beat_d.be    = be_w;
      beat_d.first = first_d;
      beat_d.last  = last_w;
      beat_d.id    = id_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.beat_valid = (state_q == ST_RUN);
  assign bus.beat       = beat_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign done_id_o      = done_id_q;
  assign done_err_o     = done_err_q;

endmodule

// File: tb/tb_spatz_vrf_sequencer.sv
// Bench for spatz_vrf_sequencer: table of ops checked through an element-level
// scoreboard, plus hand-written stall, flush, no-beat and reset sequences.
module tb_spatz_vrf_sequencer;
  import spatz_vrf_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            done, done_err, busy;
  logic [ID_W-1:0] done_id;

  spatz_vrf_sequencer_if bus ();

  spatz_vrf_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .bus        (bus),
    .done_o     (done),
    .done_id_o  (done_id),
    .done_err_o (done_err),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
    int              nb;
  } exp_done_t;

  typedef struct {
    int              vd;
    int              vstart;
    int              vl;
    int              sew;
    logic [ID_W-1:0] id;
    int              nb;
    logic            err;
  } vec_t;

  int        n_chk = 0;
  int        n_fail = 0;
  int        beats_seen = 0;
  bit        mon_en = 1'b0;
  bit        rand_rdy = 1'b0;
  seq_beat_t exp_beats[$];
  exp_done_t exp_dones[$];
  vec_t      vecs[11];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Element-level view: a byte is body when its element index lies in [vstart, vl).
  function automatic logic [7:0] model_be(int w, int vstart, int vl, int ew);
    logic [7:0] be;
    be = '0;
    for (int i = 0; i < 8; i++) begin
      int el;
      el = (w * 8 + i) / ew;
      if (el >= vstart && el < vl) be[i] = 1'b1;
    end
    return be;
  endfunction

  task automatic push_model(int vd, int vstart, int vl, int sew, logic [ID_W-1:0] id);
    int fw, lw, ew;
    seq_beat_t b;
    if (sew == 3) return;
    ew = 1 << sew;
    fw = -1;
    lw = -1;
    for (int w = 0; w < 32; w++) begin
      if (model_be(w, vstart, vl, ew) != 8'h00) begin
        if (fw < 0) fw = w;
        lw = w;
      end
    end
    if (fw < 0) return;
    for (int w = fw; w <= lw; w++) begin
      b.vreg  = 5'((vd + w / 4) % 32);
      b.word  = 2'(w % 4);
      b.be    = model_be(w, vstart, vl, ew);
      b.first = (w == fw);
      b.last  = (w == lw);
      b.id    = id;
      exp_beats.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.beat_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_req(int vd, int vstart, int vl, int sew, logic [ID_W-1:0] id);
    bus.req.id     = id;
    bus.req.vd     = 5'(vd);
    bus.req.vstart = VL_W'(vstart);
    bus.req.vl     = VL_W'(vl);
    bus.req.vsew   = 2'(sew);
    bus.req_valid  = 1'b1;
  endtask

  task automatic send_vec(vec_t v);
    int t;
    exp_done_t d;
    t = 0;
    while (!bus.req_ready && t < 1000) begin
      tick();
      t++;
    end
    if (!bus.req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    push_model(v.vd, v.vstart, v.vl, v.sew, v.id);
    d.id  = v.id;
    d.err = v.err;
    d.nb  = v.nb;
    exp_dones.push_back(d);
    drive_req(v.vd, v.vstart, v.vl, v.sew, v.id);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_dones.size() != 0) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) fail("drain_timeout");
    exp_beats.delete();
    exp_dones.delete();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
    chk({tag, "_beat_valid"}, 64'(bus.beat_valid), 64'(0));
    chk({tag, "_beat"}, 64'(bus.beat), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_done_err"}, 64'(done_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Scoreboard monitor: beats and done pulses popped in order, sampled mid-cycle.
  always @(negedge clk) begin
    seq_beat_t eb;
    exp_done_t ed;
    if (mon_en) begin
      if (bus.beat_valid && bus.beat_ready) begin
        beats_seen++;
        if (exp_beats.size() == 0) fail("unexpected_beat");
        else begin
          eb = exp_beats.pop_front();
          chk("beat", 64'(bus.beat), 64'(eb));
        end
      end
      if (done) begin
        if (exp_dones.size() == 0) fail("unexpected_done");
        else begin
          ed = exp_dones.pop_front();
          chk("done_id", 64'(done_id), 64'(ed.id));
          chk("done_err", 64'(done_err), 64'(ed.err));
          chk("beat_count", 64'(beats_seen), 64'(ed.nb));
        end
        chk("done_with_own_beat", 64'(bus.beat_valid && (bus.beat.id == done_id)), 64'(0));
        beats_seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    seq_beat_t b0;

    vecs[0]  = '{vd: 2,  vstart: 0,   vl: 8,   sew: 2, id: 3'd1, nb: 4,  err: 1'b0};
    vecs[1]  = '{vd: 0,  vstart: 3,   vl: 13,  sew: 0, id: 3'd2, nb: 2,  err: 1'b0};
    vecs[2]  = '{vd: 4,  vstart: 0,   vl: 40,  sew: 1, id: 3'd3, nb: 10, err: 1'b0};
    vecs[3]  = '{vd: 0,  vstart: 5,   vl: 5,   sew: 0, id: 3'd4, nb: 0,  err: 1'b0};
    vecs[4]  = '{vd: 0,  vstart: 0,   vl: 8,   sew: 3, id: 3'd5, nb: 0,  err: 1'b1};
    vecs[5]  = '{vd: 30, vstart: 0,   vl: 24,  sew: 2, id: 3'd6, nb: 12, err: 1'b0};
    vecs[6]  = '{vd: 1,  vstart: 7,   vl: 300, sew: 1, id: 3'd7, nb: 31, err: 1'b0};
    vecs[7]  = '{vd: 0,  vstart: 10,  vl: 11,  sew: 0, id: 3'd0, nb: 1,  err: 1'b0};
    vecs[8]  = '{vd: 0,  vstart: 200, vl: 100, sew: 0, id: 3'd1, nb: 0,  err: 1'b0};
    vecs[9]  = '{vd: 8,  vstart: 0,   vl: 256, sew: 0, id: 3'd2, nb: 32, err: 1'b0};
    vecs[10] = '{vd: 0,  vstart: 0,   vl: 0,   sew: 2, id: 3'd3, nb: 0,  err: 1'b0};

    bus.req_valid  = 1'b0;
    bus.req        = '0;
    bus.beat_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table pass with beat_ready held high, one op at a time.
    mon_en = 1'b1;
    bus.beat_ready = 1'b1;
    foreach (vecs[i]) begin
      send_vec(vecs[i]);
      drain();
    end

    // Same table back-to-back with random backpressure.
    rand_rdy = 1'b1;
    foreach (vecs[i]) send_vec(vecs[i]);
    drain();
    rand_rdy = 1'b0;
    bus.beat_ready = 1'b1;
    tick();

    // Latency, stall hold and flush on beat 2.
    mon_en = 1'b0;
    bus.beat_ready = 1'b0;
    drive_req(2, 0, 8, 2, 3'd3);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    b0 = '{vreg: 5'd2, word: 2'd0, be: 8'hFF, first: 1'b1, last: 1'b0, id: 3'd3};
    chk("first_beat_valid", 64'(bus.beat_valid), 64'(1));
    chk("first_beat", 64'(bus.beat), 64'(b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", 64'(bus.beat_valid), 64'(1));
      chk("stall_beat", 64'(bus.beat), 64'(b0));
    end
    bus.beat_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("beat1_word", 64'(bus.beat.word), 64'(1));
    chk("beat1_first", 64'(bus.beat.first), 64'(0));
    tick();
    @(negedge clk);
    chk("beat2_word", 64'(bus.beat.word), 64'(2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(bus.beat_valid), 64'(0));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_ready", 64'(bus.req_ready), 64'(1));
    for (int k = 0; k < 3; k++) begin
      chk("flush_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end

    // Ops without body: done next cycle, req_ready never drops.
    drive_req(0, 5, 5, 0, 3'd4);
    tick();
    @(negedge clk);
    chk("empty_done", 64'(done), 64'(1));
    chk("empty_done_id", 64'(done_id), 64'(4));
    chk("empty_done_err", 64'(done_err), 64'(0));
    chk("empty_ready", 64'(bus.req_ready), 64'(1));
    drive_req(0, 0, 8, 3, 3'd5);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("illegal_done", 64'(done), 64'(1));
    chk("illegal_done_id", 64'(done_id), 64'(5));
    chk("illegal_done_err", 64'(done_err), 64'(1));
    chk("illegal_ready", 64'(bus.req_ready), 64'(1));
    chk("illegal_valid", 64'(bus.beat_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("pulse_ends", 64'(done), 64'(0));

    // Reset mid-op, then a normal op from IDLE.
    drive_req(4, 0, 40, 1, 3'd5);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_reset_vals("midop_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_no_done", 64'(done), 64'(0));
    mon_en = 1'b1;
    tick();
    send_vec(vecs[0]);
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
